lfsr_search_ctrl: RTL and testbench
===================================

LFSR_SEARCH_CTRL -- requirements
Module: lfsr_search_ctrl

Interface
REQ-001 Parameter DEFAULT_STEPS, default 16'hFFFF; search-step limit used when Max_Steps = 0.
REQ-002 LFSR_Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Search_Start  input  1  search request (valid).
REQ-005 Search_Ready  output  1  request accepted on a cycle where Search_Start = 1 and Search_Ready = 1.
REQ-006 Tap_Mask  input  16  LFSR feedback tap mask, captured on accept.
REQ-007 Max_Steps  input  16  step limit, captured on accept; 0 selects DEFAULT_STEPS.
REQ-008 Search_Abort  input  1  cancels an in-flight search.
REQ-009 Compare_Found  input  1  comparator match on the current LFSR state, valid in the same cycle.
REQ-010 LFSR_Seed_Load  output  1  active-high pulse that reloads the LFSR seed.
REQ-011 LFSR_Enable  output  1  LFSR shifts once on each edge where this is high.
REQ-012 En  output  16  registered tap mask driven to the LFSR.
REQ-013 Result_Valid  output  1  result available.
REQ-014 Result_Ready  input  1  result consumed when Result_Valid = 1 and Result_Ready = 1.
REQ-015 Hit  output  1  1 = match found, 0 = limit reached without a match.
REQ-016 Step_Count  output  16  LFSR shifts performed before the match or the limit.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, SEARCH and DONE.
REQ-018 Search_Ready SHALL be 1 only in IDLE; the other states SHALL ignore Search_Start.
REQ-019 IDLE on accept: capture Tap_Mask into En and the effective limit into Limit, clear Step_Count and Hit, then go to LOAD.
REQ-020 LOAD: LFSR_Seed_Load = 1 for exactly this one cycle; LFSR_Enable = 0; the next state is SEARCH.
REQ-021 SEARCH, per cycle, priority order:
- Search_Abort: go to IDLE, no result.
- Compare_Found = 1: set Hit = 1, hold Step_Count, go to DONE.
- Step_Count == Limit: set Hit = 0, go to DONE.
- Otherwise: increment Step_Count.
REQ-022 LFSR_Enable SHALL be combinational: it is 1 only in SEARCH with Search_Abort = 0, Compare_Found = 0 and Step_Count != Limit, so shifts equal Step_Count exactly.
REQ-023 The states examined per search SHALL be Step_Count+1 (indices 0..Limit); Step_Count SHALL never exceed Limit or wrap.
REQ-024 Search_Abort in LOAD SHALL return the FSM to IDLE; in IDLE or DONE it SHALL be ignored.
REQ-025 DONE: Result_Valid = 1; Hit, Step_Count and En stay stable until handshake; on handshake the next state is IDLE.
REQ-026 A new request SHALL not be accepted in the handshake cycle (one-cycle bubble minimum).
REQ-027 Latency: accept at cycle T, LOAD at T+1, SEARCH from T+2, Result_Valid at T+3+Step_Count.
REQ-028 Tap_Mask = 0 SHALL be accepted without special handling.
REQ-029 Compare_Found outside SEARCH SHALL be ignored.

Reset
REQ-030 Reset low SHALL immediately force IDLE, Step_Count = 0, Hit = 0, En = 0, Limit = 0, Result_Valid = 0, LFSR_Enable = 0, LFSR_Seed_Load = 0 and Search_Ready = 1.
REQ-031 Reset asserted mid-search SHALL discard the search with no result.
REQ-032 The first accept SHALL be possible in the first clock edge after Reset deasserts.

Verification
REQ-033 Seed match: Max_Steps = 10, Compare_Found = 1 in the first SEARCH cycle -> LFSR_Enable never high, Hit = 1, Step_Count = 0, Result_Valid at T+3.
REQ-034 Match after shifts: Compare_Found rises in the 6th SEARCH cycle -> LFSR_Enable high for exactly 5 cycles, Hit = 1, Step_Count = 5, Result_Valid at T+8.
REQ-035 Miss and default limit:
- Max_Steps = 3, no match -> 3 enables, Hit = 0, Step_Count = 3, Result_Valid at T+6.
- Max_Steps = 0 -> Limit = 16'hFFFF.
REQ-036 Simultaneous match and limit: Max_Steps = 2, Compare_Found = 1 when Step_Count = 2 -> Hit = 1, Step_Count = 2.
REQ-037 Back-pressure: Result_Ready low for 10 cycles -> Result_Valid, Hit and Step_Count stable, Search_Ready = 0, Search_Start pulses ignored; Ready high -> IDLE next cycle.
REQ-038 Abort and reset:
- Search_Abort at Step_Count = 4 -> IDLE next cycle, no Result_Valid.
- Reset low mid-SEARCH -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/lfsr_search_ctrl_if.sv
// Handshake and LFSR-control bundle for the LFSR search controller.
// The master side issues searches and drives the comparator result.
interface lfsr_search_ctrl_if;
  logic        Search_Start;
  logic        Search_Ready;
  logic [15:0] Tap_Mask;
  logic [15:0] Max_Steps;
  logic        Search_Abort;
  logic        Compare_Found;
  logic        LFSR_Seed_Load;
  logic        LFSR_Enable;
  logic [15:0] En;
  logic        Result_Valid;
  logic        Result_Ready;
  logic        Hit;
  logic [15:0] Step_Count;

  modport master (
    output Search_Start, Tap_Mask, Max_Steps,
    output Search_Abort, Compare_Found, Result_Ready,
    input  Search_Ready, LFSR_Seed_Load, LFSR_Enable,
    input  En, Result_Valid, Hit, Step_Count
  );

  modport slave (
    input  Search_Start, Tap_Mask, Max_Steps,
    input  Search_Abort, Compare_Found, Result_Ready,
    output Search_Ready, LFSR_Seed_Load, LFSR_Enable,
    output En, Result_Valid, Hit, Step_Count
  );
endinterface

// File: rtl/lfsr_search_ctrl.sv
// Sequences an external LFSR: seed load, shift until a comparator match
// or the step limit, then hold the result until it is consumed.
module lfsr_search_ctrl #(
  parameter logic [15:0] DEFAULT_STEPS = 16'hFFFF
) (
  input logic               LFSR_Clock,
  input logic               Reset,
  lfsr_search_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SEARCH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic [15:0] limit;
  logic [15:0] step;
  logic [15:0] mask;
  logic        hit;
  logic        at_limit;

  assign at_limit = (step == limit);

  assign bus.Search_Ready   = (state == IDLE);
  assign bus.LFSR_Seed_Load = (state == LOAD);
  assign bus.Result_Valid   = (state == DONE);
  assign bus.Hit            = hit;
  assign bus.Step_Count     = step;
  assign bus.En             = mask;

  // Shift only when this cycle neither terminates nor aborts the search,
  // so the number of shifts always equals the step count.
  assign bus.LFSR_Enable = (state == SEARCH)
                         && !bus.Search_Abort
                         && !bus.Compare_Found
                         && !at_limit;

  always_ff @(posedge LFSR_Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      limit <= '0;
      step  <= '0;
      mask  <= '0;
      hit   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Search_Start) begin
            mask  <= bus.Tap_Mask;
            limit <= (bus.Max_Steps == '0) ? DEFAULT_STEPS
                                           : bus.Max_Steps;
            step  <= '0;
            hit   <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= bus.Search_Abort ? IDLE : SEARCH;
        end
        SEARCH: begin
          if (bus.Search_Abort) begin
            state <= IDLE;
          end else if (bus.Compare_Found) begin
            hit   <= 1'b1;
            state <= DONE;
          end else if (at_limit) begin
            hit   <= 1'b0;
            state <= DONE;
          end else begin
            step <= step + 16'd1;
          end
        end
        DONE: begin
          if (bus.Result_Ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_search_ctrl.sv
// Directed and randomized checks of lfsr_search_ctrl against an
// outcome model derived from the search rules.
module tb_lfsr_search_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lfsr_search_ctrl_if bus ();

  lfsr_search_ctrl dut (
    .LFSR_Clock (clk),
    .Reset      (rst_n),
    .bus        (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(bus.Search_Ready), 32'd1);
    chk({tag, "_en"},    32'(bus.LFSR_Enable), 32'd0);
    chk({tag, "_seed"},  32'(bus.LFSR_Seed_Load), 32'd0);
    chk({tag, "_valid"}, 32'(bus.Result_Valid), 32'd0);
    chk({tag, "_hit"},   32'(bus.Hit), 32'd0);
    chk({tag, "_steps"}, 32'(bus.Step_Count), 32'd0);
    chk({tag, "_mask"},  32'(bus.En), 32'd0);
  endtask

  // m: SEARCH index where Compare_Found is raised (-1 none)
  // a: SEARCH index of abort (-1 none, -2 abort during LOAD)
  // r: SEARCH index where reset is pulsed (-1 none)
  // hold: cycles Result_Ready stays low in DONE
  // Called and returns at a falling edge while the DUT is idle.
  task automatic search(input logic [15:0] tmask,
                        input logic [15:0] mx,
                        input int m, input int a,
                        input int r, input int hold);
    int lim, stop, kind, en_seen, n;
    lim  = (mx == 16'd0) ? 65535 : int'(mx);
    stop = 0;
    kind = 0;
    for (int k = 0; ; k++) begin
      if (k == r)   begin kind = 3; stop = k; break; end
      if (k == a)   begin kind = 2; stop = k; break; end
      if (k == m)   begin kind = 1; stop = k; break; end
      if (k == lim) begin kind = 0; stop = k; break; end
    end

    chk("idle_ready", 32'(bus.Search_Ready), 32'd1);
    bus.Tap_Mask     = tmask;
    bus.Max_Steps    = mx;
    bus.Search_Start = 1'b1;
    @(negedge clk);
    n = 1;
    bus.Search_Start  = 1'b0;
    bus.Tap_Mask      = 16'($urandom);
    bus.Max_Steps     = 16'($urandom);
    bus.Compare_Found = 1'($urandom);
    #1;
    chk("load_seed", 32'(bus.LFSR_Seed_Load), 32'd1);
    chk("load_en", 32'(bus.LFSR_Enable), 32'd0);
    chk("load_ready", 32'(bus.Search_Ready), 32'd0);
    if (a == -2) begin
      bus.Search_Abort = 1'b1;
      @(negedge clk);
      bus.Search_Abort  = 1'b0;
      bus.Compare_Found = 1'b0;
      chk("abort_load_ready", 32'(bus.Search_Ready), 32'd1);
      chk("abort_load_valid", 32'(bus.Result_Valid), 32'd0);
      return;
    end

    en_seen = 0;
    for (int k = 0; k <= stop; k++) begin
      @(negedge clk);
      n++;
      bus.Compare_Found = (k == m);
      bus.Search_Abort  = (k == a);
      if (kind == 3 && k == stop) begin
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.Compare_Found = 1'b0;
        bus.Search_Abort  = 1'b0;
        chk("midrst_after_valid", 32'(bus.Result_Valid), 32'd0);
        chk("midrst_after_ready", 32'(bus.Search_Ready), 32'd1);
        return;
      end
      #1;
      if (bus.LFSR_Enable) en_seen++;
      chk("search_en", 32'(bus.LFSR_Enable), 32'(k < stop));
      chk("search_steps", 32'(bus.Step_Count), 32'(k));
      chk("search_valid", 32'(bus.Result_Valid), 32'd0);
    end

    @(negedge clk);
    n++;
    bus.Compare_Found = 1'b0;
    bus.Search_Abort  = 1'b0;
    chk("shift_total", 32'(en_seen), 32'(stop));
    if (kind == 2) begin
      chk("abort_ready", 32'(bus.Search_Ready), 32'd1);
      chk("abort_valid", 32'(bus.Result_Valid), 32'd0);
      return;
    end
    chk("done_valid", 32'(bus.Result_Valid), 32'd1);
    chk("done_latency", 32'(n), 32'(stop + 3));
    chk("done_hit", 32'(bus.Hit), 32'(kind == 1));
    chk("done_steps", 32'(bus.Step_Count), 32'(stop));
    chk("done_mask", 32'(bus.En), 32'(tmask));

    for (int i = 0; i < hold; i++) begin
      bus.Result_Ready  = 1'b0;
      bus.Search_Start  = 1'($urandom);
      bus.Search_Abort  = 1'($urandom);
      bus.Compare_Found = 1'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(bus.Result_Valid), 32'd1);
      chk("bp_hit", 32'(bus.Hit), 32'(kind == 1));
      chk("bp_steps", 32'(bus.Step_Count), 32'(stop));
      chk("bp_mask", 32'(bus.En), 32'(tmask));
      chk("bp_ready", 32'(bus.Search_Ready), 32'd0);
      chk("bp_seed", 32'(bus.LFSR_Seed_Load), 32'd0);
    end

    // Start held high through the handshake must not be taken
    bus.Result_Ready  = 1'b1;
    bus.Search_Start  = 1'b1;
    bus.Search_Abort  = 1'b0;
    bus.Compare_Found = 1'b0;
    @(negedge clk);
    bus.Result_Ready = 1'b0;
    bus.Search_Start = 1'b0;
    chk("hs_valid", 32'(bus.Result_Valid), 32'd0);
    chk("hs_ready", 32'(bus.Search_Ready), 32'd1);
    chk("hs_seed", 32'(bus.LFSR_Seed_Load), 32'd0);
  endtask

  initial begin
    int m, a, hold;
    logic [15:0] mx;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.Search_Start  = 1'b0;
    bus.Tap_Mask      = 16'h0;
    bus.Max_Steps     = 16'h0;
    bus.Search_Abort  = 1'b0;
    bus.Compare_Found = 1'b0;
    bus.Result_Ready  = 1'b0;
    #2 chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    search(16'hB400, 16'd10, 0, -1, -1, 0);
    search(16'hD008, 16'd20, 5, -1, -1, 0);
    search(16'h1234, 16'd3, -1, -1, -1, 0);
    search(16'h8001, 16'd0, 40, -1, -1, 0);
    search(16'h00FF, 16'd2, 2, -1, -1, 0);
    search(16'hA5A5, 16'd4, -1, -1, -1, 10);
    search(16'h0F0F, 16'd10, -1, 4, -1, 0);
    search(16'h3C3C, 16'd10, -1, -2, -1, 0);
    search(16'h0000, 16'd5, -1, -1, -1, 1);
    search(16'h7777, 16'd30, -1, -1, 7, 0);

    for (int it = 0; it < 40; it++) begin
      mx   = 16'($urandom_range(0, 24));
      m    = ($urandom_range(0, 2) == 0) ? -1
                                         : int'($urandom_range(0, 30));
      if (mx == 16'd0 && m < 0) m = int'($urandom_range(0, 30));
      a    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12))
                                         : -1;
      if ($urandom_range(0, 15) == 0) a = -2;
      hold = int'($urandom_range(0, 3));
      search(16'($urandom), mx, m, a, -1, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
